bpu_update_sched: RTL and testbench

//  Sequences predictor-table training. Takes up to two branch-resolution updates per cycle

---
 rtl/bpu_update_sched.sv | 159 +++++++++++++++
 tb/tb_bpu_update_sched.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpu_update_sched.sv
// Predictor-table training scheduler: orders and squashes dual-slot branch updates,
// queues them, drains one table write per cycle, and sweeps the table after reset.
module bpu_update_sched #(
   parameter int unsigned IDX_W = 9,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             u1_valid,
   input  logic [31:0]      u1_pc,
   input  logic             u1_taken,
   input  logic [31:0]      u1_target,
   input  logic [1:0]       u1_type,
   input  logic             u1_mispred,
   input  logic             u2_valid,
   input  logic [31:0]      u2_pc,
   input  logic             u2_taken,
   input  logic [31:0]      u2_target,
   input  logic [1:0]       u2_type,
   input  logic             u2_mispred,
   output logic             wr_valid,
   input  logic             wr_ready,
   output logic [31:0]      wr_pc,
   output logic             wr_taken,
   output logic [31:0]      wr_target,
   output logic [1:0]       wr_type,
   output logic             clr_valid,
   output logic [IDX_W-1:0] clr_idx,
   output logic             redirect,
   output logic [31:0]      redirect_pc,
   output logic             busy,
   output logic [CNT_W-1:0] drop_cnt
);

   localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_FW = PTR_W + 1;

   typedef struct packed {
      logic [31:0] pc;
      logic        taken;
      logic [31:0] target;
      logic [1:0]  btype;
   } upd_t;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    clr_idx_q, clr_idx_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr_nx;
   logic [CNT_FW-1:0]   count_q, count_d;
   logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
   upd_t                mem_q [DEPTH];
   upd_t                mem_d [DEPTH];

   logic                u1_acc, u2_acc, merge, pop;
   upd_t                upd1, upd2, ent0, ent1;
   logic [1:0]          n_req, n_push, n_drop;
   logic [CNT_FW:0]     free_slots;
   logic [CNT_W:0]      drop_sum;

   // Slot ordering: slot1 older; a slot1 mispredict squashes slot2; same-PC pair keeps slot2 only.
   always_comb begin
      u1_acc = u1_valid;
      u2_acc = u2_valid && !(u1_valid && u1_mispred);
      merge  = u1_acc && u2_acc && (u1_pc == u2_pc);
      upd1   = '{pc: u1_pc, taken: u1_taken, target: u1_target, btype: u1_type};
      upd2   = '{pc: u2_pc, taken: u2_taken, target: u2_target, btype: u2_type};
      ent0   = (u1_acc && !merge) ? upd1 : upd2;
      ent1   = upd2;
      n_req  = 2'(u1_acc && !merge) + 2'(u2_acc);
   end

   assign wr_valid  = (count_q != '0) && (state_q == ST_RUN);
   assign pop       = wr_valid && wr_ready;
   assign wr_ptr_nx = wr_ptr_q + PTR_W'(1);

   // Next state: FIFO push/pop, drop accounting, init sweep.
   always_comb begin
      state_d    = state_q;
      clr_idx_d  = clr_idx_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      drop_cnt_d = drop_cnt_q;
      mem_d      = mem_q;
      n_push     = 2'd0;

      // A same-cycle pop frees its slot before the pushes are sized.
      free_slots = (CNT_FW+1)'(DEPTH) - (CNT_FW+1)'(count_q) + (CNT_FW+1)'(pop);
      if (state_q == ST_RUN)
         n_push = (free_slots >= (CNT_FW+1)'(n_req)) ? n_req : 2'(free_slots);
      n_drop = n_req - n_push;

      if (n_push != 2'd0) mem_d[wr_ptr_q]  = ent0;
      if (n_push == 2'd2) mem_d[wr_ptr_nx] = ent1;
      wr_ptr_d = wr_ptr_q + PTR_W'(n_push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_FW'(n_push) - CNT_FW'(pop);

      drop_sum   = {1'b0, drop_cnt_q} + (CNT_W+1)'(n_drop);
      drop_cnt_d = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];

      case (state_q)
         ST_INIT: begin
            clr_idx_d = clr_idx_q + IDX_W'(1);
            if (clr_idx_q == {IDX_W{1'b1}}) state_d = ST_RUN;
         end
         ST_RUN:  state_d = ST_RUN;
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_INIT;
         clr_idx_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_idx_q  <= clr_idx_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Payload storage needs no reset; occupancy alone qualifies it.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign wr_pc     = mem_q[rd_ptr_q].pc;
   assign wr_taken  = mem_q[rd_ptr_q].taken;
   assign wr_target = mem_q[rd_ptr_q].target;
   assign wr_type   = mem_q[rd_ptr_q].btype;
   assign clr_valid = (state_q == ST_INIT);
   assign busy      = (state_q == ST_INIT);
   assign clr_idx   = clr_idx_q;
   assign drop_cnt  = drop_cnt_q;

   // Zero-latency front-end redirect, oldest mispredict wins.
   always_comb begin
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      if (u1_valid && u1_mispred) begin
         redirect    = 1'b1;
         redirect_pc = u1_taken ? u1_target : u1_pc + 32'd4;
      end else if (u2_valid && u2_mispred) begin
         redirect    = 1'b1;
         redirect_pc = u2_taken ? u2_target : u2_pc + 32'd4;
      end
   end

endmodule

// File: tb/tb_bpu_update_sched.sv
// Bench for bpu_update_sched: directed tables/sequences plus random traffic vs a queue model.
module tb_bpu_update_sched;

   localparam int unsigned IDX_W = 4;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_W = 8;
   localparam int          NENT  = 16;
   localparam int          DMAX  = 255;

   logic             clk = 1'b0;
   logic             reset;
   logic             u1_valid, u1_taken, u1_mispred;
   logic [31:0]      u1_pc, u1_target;
   logic [1:0]       u1_type;
   logic             u2_valid, u2_taken, u2_mispred;
   logic [31:0]      u2_pc, u2_target;
   logic [1:0]       u2_type;
   logic             wr_valid, wr_ready, wr_taken;
   logic [31:0]      wr_pc, wr_target;
   logic [1:0]       wr_type;
   logic             clr_valid, redirect, busy;
   logic [IDX_W-1:0] clr_idx;
   logic [31:0]      redirect_pc;
   logic [CNT_W-1:0] drop_cnt;

   bpu_update_sched #(.IDX_W(IDX_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .u1_valid(u1_valid), .u1_pc(u1_pc), .u1_taken(u1_taken), .u1_target(u1_target),
      .u1_type(u1_type), .u1_mispred(u1_mispred),
      .u2_valid(u2_valid), .u2_pc(u2_pc), .u2_taken(u2_taken), .u2_target(u2_target),
      .u2_type(u2_type), .u2_mispred(u2_mispred),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_pc(wr_pc), .wr_taken(wr_taken),
      .wr_target(wr_target), .wr_type(wr_type),
      .clr_valid(clr_valid), .clr_idx(clr_idx), .redirect(redirect), .redirect_pc(redirect_pc),
      .busy(busy), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic        taken;
      logic [31:0] target;
      logic [1:0]  btype;
   } ent_t;

   typedef struct {
      logic        u1v; logic [31:0] u1pc; logic u1t; logic [31:0] u1tgt; logic u1m;
      logic        u2v; logic [31:0] u2pc; logic u2t; logic [31:0] u2tgt; logic u2m;
      logic        exp_rd; logic [31:0] exp_rpc;
   } rd_vec_t;

   ent_t mq[$];
   int   m_init;
   int   m_drops;
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_check();
      logic        busy_e, wv_e, rd_e;
      logic [31:0] rpc_e;
      busy_e = (m_init > 0);
      wv_e   = !busy_e && (mq.size() > 0);
      chk("busy", 64'(busy), 64'(busy_e));
      chk("clr_valid", 64'(clr_valid), 64'(busy_e));
      if (busy_e) chk("clr_idx", 64'(clr_idx), 64'(NENT - m_init));
      chk("wr_valid", 64'(wr_valid), 64'(wv_e));
      if (wv_e) begin
         chk("wr_pc", 64'(wr_pc), 64'(mq[0].pc));
         chk("wr_taken", 64'(wr_taken), 64'(mq[0].taken));
         chk("wr_target", 64'(wr_target), 64'(mq[0].target));
         chk("wr_type", 64'(wr_type), 64'(mq[0].btype));
      end
      rd_e  = 1'b0;
      rpc_e = 32'h0;
      if (u1_valid && u1_mispred) begin
         rd_e = 1'b1; rpc_e = u1_taken ? u1_target : u1_pc + 32'd4;
      end else if (u2_valid && u2_mispred) begin
         rd_e = 1'b1; rpc_e = u2_taken ? u2_target : u2_pc + 32'd4;
      end
      chk("redirect", 64'(redirect), 64'(rd_e));
      if (rd_e) chk("redirect_pc", 64'(redirect_pc), 64'(rpc_e));
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drops));
   endtask

   task automatic model_update();
      ent_t e[$];
      logic a1, a2;
      a1 = u1_valid;
      a2 = u2_valid && !(u1_valid && u1_mispred);
      if (a1 && a2 && (u1_pc == u2_pc)) begin
         e.push_back('{u2_pc, u2_taken, u2_target, u2_type});
      end else begin
         if (a1) e.push_back('{u1_pc, u1_taken, u1_target, u1_type});
         if (a2) e.push_back('{u2_pc, u2_taken, u2_target, u2_type});
      end
      if (m_init == 0 && mq.size() > 0 && wr_ready) void'(mq.pop_front());
      foreach (e[i]) begin
         if (m_init == 0 && mq.size() < DEPTH) mq.push_back(e[i]);
         else m_drops = (m_drops < DMAX) ? m_drops + 1 : DMAX;
      end
      if (m_init > 0) m_init--;
   endtask

   task automatic step();
      #1;
      model_check();
      model_update();
      @(negedge clk);
   endtask

   task automatic idle();
      u1_valid = 0; u1_pc = 0; u1_taken = 0; u1_target = 0; u1_type = 0; u1_mispred = 0;
      u2_valid = 0; u2_pc = 0; u2_taken = 0; u2_target = 0; u2_type = 0; u2_mispred = 0;
   endtask

   task automatic set_u1(input logic [31:0] pc, input logic t, input logic [31:0] tgt, input logic m);
      u1_valid = 1; u1_pc = pc; u1_taken = t; u1_target = tgt; u1_type = 2'b00; u1_mispred = m;
   endtask

   task automatic set_u2(input logic [31:0] pc, input logic t, input logic [31:0] tgt, input logic m);
      u2_valid = 1; u2_pc = pc; u2_taken = t; u2_target = tgt; u2_type = 2'b01; u2_mispred = m;
   endtask

   task automatic do_reset();
      idle();
      reset = 1;
      @(negedge clk);
      @(negedge clk);
      reset = 0;
      mq.delete();
      m_init  = NENT;
      m_drops = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rd_vec_t vt[6];
      wr_ready = 1;
      do_reset();

      // Reset state and sweep timing; an update during INIT is dropped.
      #1;
      chk("rst_busy", 64'(busy), 64'd1);
      chk("rst_clr_idx", 64'(clr_idx), 64'd0);
      chk("rst_drop", 64'(drop_cnt), 64'd0);
      chk("rst_wr_valid", 64'(wr_valid), 64'd0);
      chk("rst_redirect", 64'(redirect), 64'd0);
      set_u1(32'h40, 0, 32'h0, 0);
      for (int i = 0; i < NENT; i++) begin
         #1 chk("sweep_idx", 64'(clr_idx), 64'(i));
         step();
         idle();
      end
      #1;
      chk("sweep_done_busy", 64'(busy), 64'd0);
      chk("init_drop", 64'(drop_cnt), 64'd1);
      chk("init_no_entry", 64'(wr_valid), 64'd0);

      // Slot1 mispredict: redirect to target, slot2 squashed, one entry.
      set_u1(32'h1c000010, 1, 32'h1c000100, 1);
      set_u2(32'h1c000014, 0, 32'h0, 0);
      #1 chk("mp_redirect_pc", 64'(redirect_pc), 64'h1c000100);
      step(); idle();
      #1 chk("mp_entry_pc", 64'(wr_pc), 64'h1c000010);
      step();
      #1 chk("mp_single_entry", 64'(wr_valid), 64'd0);

      // Same PC in both slots merges into one entry carrying slot2.
      set_u1(32'h1c000020, 0, 32'h111, 0);
      set_u2(32'h1c000020, 1, 32'h222, 0);
      step(); idle();
      #1 chk("merge_target", 64'(wr_target), 64'h222);
      chk("merge_taken", 64'(wr_taken), 64'd1);
      step();
      #1 chk("merge_single", 64'(wr_valid), 64'd0);

      // Backpressure: five updates into four slots, then in-order drain.
      wr_ready = 0;
      for (int k = 0; k < 5; k++) begin
         set_u1(32'h1000 + 32'(16*k), 0, 32'h0, 0);
         step();
      end
      idle();
      #1 chk("full_drop", 64'(drop_cnt), 64'd2);
      chk("stall_pc0", 64'(wr_pc), 64'h1000);
      step();
      #1 chk("stall_pc1", 64'(wr_pc), 64'h1000);
      wr_ready = 1;
      for (int k = 0; k < 4; k++) begin
         #1 chk("drain_pc", 64'(wr_pc), 64'h1000 + 64'(16*k));
         step();
      end
      #1 chk("drain_empty", 64'(wr_valid), 64'd0);

      // Full FIFO with a pop and two pushes in one cycle.
      wr_ready = 0;
      for (int k = 0; k < 4; k++) begin
         set_u1(32'h2000 + 32'(16*k), 0, 32'h0, 0);
         step();
      end
      wr_ready = 1;
      set_u1(32'h3000, 0, 32'h0, 0);
      set_u2(32'h3010, 0, 32'h0, 0);
      step(); idle();
      #1 chk("pushpop_drop", 64'(drop_cnt), 64'd3);
      for (int k = 0; k < 4; k++) begin
         #1 chk("pushpop_order", 64'(wr_pc), (k < 3) ? 64'h2010 + 64'(16*k) : 64'h3000);
         step();
      end

      // Redirect vectors.
      vt[0] = '{1, 32'h1c000010, 1, 32'h1c000100, 1, 1, 32'h1c000018, 0, 32'h0, 0, 1, 32'h1c000100};
      vt[1] = '{0, 32'h0, 0, 32'h0, 0, 1, 32'hfffffffc, 0, 32'h1234, 1, 1, 32'h00000000};
      vt[2] = '{1, 32'h500, 0, 32'h900, 1, 1, 32'h600, 1, 32'h700, 1, 1, 32'h504};
      vt[3] = '{1, 32'h500, 1, 32'h900, 0, 1, 32'h600, 1, 32'h700, 0, 0, 32'h0};
      vt[4] = '{1, 32'h500, 1, 32'h900, 0, 1, 32'h600, 1, 32'h800, 1, 1, 32'h800};
      vt[5] = '{0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0, 1, 0, 32'h0};
      foreach (vt[i]) begin
         idle();
         if (vt[i].u1v) set_u1(vt[i].u1pc, vt[i].u1t, vt[i].u1tgt, vt[i].u1m);
         if (vt[i].u2v) set_u2(vt[i].u2pc, vt[i].u2t, vt[i].u2tgt, vt[i].u2m);
         #1 chk("tbl_redirect", 64'(redirect), 64'(vt[i].exp_rd));
         if (vt[i].exp_rd) chk("tbl_redirect_pc", 64'(redirect_pc), 64'(vt[i].exp_rpc));
         step();
      end
      idle();
      for (int k = 0; k < 8; k++) step();

      // Drop counter saturation with two refusals per cycle.
      wr_ready = 0;
      for (int k = 0; k < 140; k++) begin
         set_u1(32'h4000, 0, 32'h0, 0);
         set_u2(32'h4004, 0, 32'h0, 0);
         step();
      end
      #1 chk("sat_drop", 64'(drop_cnt), 64'd255);
      step();
      #1 chk("sat_hold", 64'(drop_cnt), 64'd255);
      idle();
      wr_ready = 1;
      for (int k = 0; k < 6; k++) step();

      // Random traffic, with a reset in the middle.
      for (int n = 0; n < 700; n++) begin
         if (n == 350) do_reset();
         idle();
         if ($urandom_range(0, 9) < 6)
            set_u1(($urandom_range(0, 3) == 0) ? $urandom : 32'h1000 + 32'(4*$urandom_range(0, 3)),
                   1'($urandom), $urandom, $urandom_range(0, 9) < 2);
         if ($urandom_range(0, 9) < 6)
            set_u2(($urandom_range(0, 3) == 0) ? $urandom : 32'h1000 + 32'(4*$urandom_range(0, 3)),
                   1'($urandom), $urandom, $urandom_range(0, 9) < 2);
         u1_type  = 2'($urandom_range(0, 2));
         u2_type  = 2'($urandom_range(0, 2));
         wr_ready = 1'($urandom);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
